// File: rtl/inst_mem_loader.sv
// Byte-stream loader that frames a word count plus little-endian instruction words into
// instruction-memory writes. Optional trailing XOR checksum under INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR} state_t;

  localparam logic [63:0] ADDR_MASK64 = (64'd1 << ADDR_W) - 64'd1;
  localparam logic [31:0] ADDR_MASK   = ADDR_MASK64[31:0];
  localparam logic [31:0] MAX_W       = 32'(MAX_WORDS);

  state_t      state, next_state;
  logic [15:0] count;
  logic [1:0]  byte_idx;
  logic [23:0] byte_buf;
  logic        accept;
  logic        idle_like;
  logic [15:0] count_full;
  logic        last_word;
  logic [31:0] addr_next;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign in_ready   = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
  assign busy       = (state == HDR0) || (state == HDR1) || (state == DATA) ||
                      (state == WRITE) || (state == CSUM);
  assign accept     = in_valid && in_ready;
  assign idle_like  = (state == IDLE) || (state == DONE) || (state == ERR);
  assign count_full = {in_data, count[7:0]};
  assign last_word  = (word_cnt + 16'd1) == count;
  assign addr_next  = {14'd0, word_cnt, 2'b00} & ADDR_MASK;

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = HDR0;
      HDR0: if (accept) next_state = HDR1;
      HDR1: if (accept) begin
        if (count_full == 16'd0)
`ifdef INST_LOADER_CHECKSUM_EN
          next_state = CSUM;
`else
          next_state = DONE;
`endif
        else if ({16'd0, count_full} > MAX_W) next_state = ERR;
        else                                  next_state = DATA;
      end
      DATA: if (accept && byte_idx == 2'd3) next_state = WRITE;
      WRITE: begin
        if (last_word)
`ifdef INST_LOADER_CHECKSUM_EN
          next_state = CSUM;
`else
          next_state = DONE;
`endif
        else
          next_state = DATA;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM: if (accept) next_state = (in_data == csum) ? DONE : ERR;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      byte_idx  <= '0;
      byte_buf  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state   <= next_state;
      // Status outputs are registered from next_state so they line up with the state register.
      mem_we  <= (next_state == WRITE);
      cpu_rst <= (next_state == HDR0) || (next_state == HDR1) || (next_state == DATA) ||
                 (next_state == WRITE) || (next_state == CSUM) || (next_state == ERR);
      done    <= (next_state == DONE);
      err     <= (next_state == ERR);

      if (idle_like && start) begin
        word_cnt <= '0;
        byte_idx <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end

      if (accept && state == HDR0) count[7:0]  <= in_data;
      if (accept && state == HDR1) count[15:8] <= in_data;

      if (accept && state == DATA) begin
        byte_idx <= byte_idx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
        csum     <= csum ^ in_data;
`endif
        if (byte_idx == 2'd3) begin
          mem_wdata <= {in_data, byte_buf};
          mem_addr  <= addr_next;
        end else begin
          byte_buf[{byte_idx, 3'b000} +: 8] <= in_data;
        end
      end

      if (state == WRITE) word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader; checksum steps follow INST_LOADER_CHECKSUM_EN.
module tb_inst_mem_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_rst, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_cnt;

  int vectors = 0, miscompares = 0;
  int we_count = 0, we_run = 0, we_maxrun = 0;
  logic [7:0] tb_xor;

  inst_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      we_count = we_count + 1;
      we_run   = we_run + 1;
      if (we_run > we_maxrun) we_maxrun = we_run;
    end else begin
      we_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    tb_xor = 8'h00;
  endtask

  // Offer one byte, wait (bounded) for in_ready, transfer it; optional idle gap after.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
    for (int i = 0; i < 4; i++) begin
      tb_xor = tb_xor ^ w[8*i +: 8];
      send_byte(w[8*i +: 8], (i < 3) ? gap : 1'b0);
    end
    check("we_pulse", {31'd0, mem_we}, 32'd1);
    check("addr", mem_addr, addr);
    check("wdata", mem_wdata, w);
  endtask

  // Finish frame (checksum byte when enabled) and check a clean completion.
  task automatic finish_ok(input logic [15:0] n);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(tb_xor, 1'b0);
`else
    @(posedge clk); #1;
`endif
    check("done", {31'd0, done}, 32'd1);
    check("cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
    check("word_cnt", {16'd0, word_cnt}, {16'd0, n});
    check("busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; tb_xor = 8'h00;
    #12;
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_flags", {27'd0, cpu_rst, busy, done, err, in_ready}, 32'd0);
    check("rst_cnt", {16'd0, word_cnt}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Basic two-word frame
    do_start();
    check("start_ready", {31'd0, in_ready}, 32'd1);
    check("start_busy_rst", {30'd0, busy, cpu_rst}, 32'd3);
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    we_count = 0; we_maxrun = 0;
    send_word(32'h002081B3, 32'd0, 1'b0);
    check("write_not_ready", {31'd0, in_ready}, 32'd0);
    send_word(32'h403202B3, 32'd4, 1'b0);
    check("cpu_rst_during_last_we", {31'd0, cpu_rst}, 32'd1);
    finish_ok(16'd2);
    check("we_count_basic", we_count, 32'd2);

`ifndef INST_LOADER_CHECKSUM_EN
    // A stray byte after the frame is not consumed
    in_data = 8'hAA; in_valid = 1'b1;
    @(posedge clk); #1;
    check("done_ignores_byte", {30'd0, in_ready, done}, 32'd1);
    in_valid = 1'b0;
`endif

    // Same frame with in_valid toggling
    do_start();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    we_count = 0; we_maxrun = 0;
    send_word(32'h002081B3, 32'd0, 1'b1);
    send_word(32'h403202B3, 32'd4, 1'b1);
    finish_ok(16'd2);
    check("toggle_we_count", we_count, 32'd2);
    check("toggle_we_width", we_maxrun, 32'd1);

    // Oversized count
    do_start();
    we_count = 0;
    send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
    check("ovf_err_rst", {29'd0, err, cpu_rst, done}, 32'd6);
    check("ovf_idle", {30'd0, busy, in_ready}, 32'd0);
    repeat (3) @(posedge clk); #1;
    check("ovf_no_writes", we_count, 32'd0);
    check("ovf_err_hold", {31'd0, err}, 32'd1);

    // Reset mid-load after 6 data bytes
    do_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    we_count = 0;
    send_word(32'h00100513, 32'd0, 1'b0);
    send_byte(8'h93, 1'b0); send_byte(8'h05, 1'b0);
    rst = 1'b1; #2;
    check("abort_outs", {28'd0, mem_we, cpu_rst, busy, done, err, in_ready}, 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    check("abort_cnt", {16'd0, word_cnt}, 32'd0);
    @(negedge clk) rst = 1'b0;
    check("abort_one_write", we_count, 32'd1);
    do_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_word(32'h00100513, 32'd0, 1'b0);
    send_word(32'h00200593, 32'd4, 1'b0);
    finish_ok(16'd2);

    // Start pulsed mid-DATA is ignored
    do_start();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    tb_xor = 8'h93 ^ 8'h02;
    send_byte(8'h93, 1'b0); send_byte(8'h02, 1'b0);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    check("start_ignored_busy", {31'd0, busy}, 32'd1);
    tb_xor = tb_xor ^ 8'h11 ^ 8'h00;
    send_byte(8'h11, 1'b0); send_byte(8'h00, 1'b0);
    check("mid_start_wdata", mem_wdata, 32'h00110293);
    finish_ok(16'd1);

`ifdef INST_LOADER_CHECKSUM_EN
    // Bad checksum
    do_start();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_word(32'h00110293, 32'd0, 1'b0);
    send_byte(tb_xor ^ 8'h01, 1'b0);
    check("csum_bad", {29'd0, err, cpu_rst, done}, 32'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
